// File: rtl/vga_frame_reader_if.sv
// Frame-buffer read port plus VGA pin bundle for vga_frame_reader.
// The reader is the master: it drives the read address and the pins and samples the read data.
interface vga_frame_reader_if #(
    parameter int AW = 15,
    parameter int DW = 3
);
    logic [AW-1:0] addr_out;
    logic [DW-1:0] data_in;
    logic          vga_r;
    logic          vga_g;
    logic          vga_b;
    logic          vga_hsync;
    logic          vga_vsync;
    logic          frame_start;

    modport master (
        output addr_out,
        input  data_in,
        output vga_r,
        output vga_g,
        output vga_b,
        output vga_hsync,
        output vga_vsync,
        output frame_start
    );

    modport slave (
        input  addr_out,
        output data_in,
        input  vga_r,
        input  vga_g,
        input  vga_b,
        input  vga_hsync,
        input  vga_vsync,
        input  frame_start
    );
endinterface

// File: rtl/vga_frame_reader.sv
// VGA timing generator and frame-buffer reader: upscales a low-res buffer by 2**SCALE_SHIFT
// and aligns the RAM's one-cycle read latency with sync/blank on registered pins.
module vga_frame_reader #(
    parameter int AW          = 15,
    parameter int DW          = 3,
    parameter int FB_W        = 160,
    parameter int FB_H        = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int H_VIS       = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VIS       = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit SYNC_POL    = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    vga_frame_reader_if.master  bus
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_VIS_C = HW'(H_VIS);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [HW-1:0] FB_W_H  = HW'(FB_W);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_VIS_C = VW'(V_VIS);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_VIS + V_FP + V_SYNC);
    localparam logic [VW-1:0] FB_H_V  = VW'(FB_H);
    localparam logic [AW-1:0] FB_W_A  = AW'(FB_W);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [AW-1:0] row_base;
    logic          h_wrap;
    logic          v_wrap;
    logic          row_last_sub;

    logic          act_t0;
    logic          hs_t0;
    logic          vs_t0;
    logic [AW-1:0] addr_t0;

    logic          act_d1, act_d2;
    logic          hs_d1,  hs_d2;
    logic          vs_d1,  vs_d2;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] rgb_q;
    logic          hsync_q;
    logic          vsync_q;

    assign h_wrap       = (h_cnt == H_LAST);
    assign v_wrap       = (v_cnt == V_LAST);
    assign row_last_sub = &v_cnt[SCALE_SHIFT-1:0];

    // row_base tracks (v>>S)*FB_W by accumulation, so no multiplier is needed.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            row_base <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            if (v_wrap) begin
                v_cnt    <= '0;
                row_base <= '0;
            end else begin
                v_cnt <= v_cnt + 1'b1;
                if (row_last_sub) begin
                    row_base <= row_base + FB_W_A;
                end
            end
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_comb begin
        act_t0  = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C) &&
                  ((h_cnt >> SCALE_SHIFT) < FB_W_H) &&
                  ((v_cnt >> SCALE_SHIFT) < FB_H_V);
        hs_t0   = ((h_cnt >= HS_BEG) && (h_cnt < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vs_t0   = ((v_cnt >= VS_BEG) && (v_cnt < VS_END)) ? SYNC_POL : ~SYNC_POL;
        addr_t0 = act_t0 ? (row_base + AW'(h_cnt >> SCALE_SHIFT)) : '0;
    end

    // Three-stage alignment: address at T1, RAM data at T2, pins at T3.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            act_d1  <= 1'b0;
            act_d2  <= 1'b0;
            hs_d1   <= ~SYNC_POL;
            hs_d2   <= ~SYNC_POL;
            vs_d1   <= ~SYNC_POL;
            vs_d2   <= ~SYNC_POL;
            rgb_q   <= '0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
        end else begin
            addr_q  <= addr_t0;
            act_d1  <= act_t0;
            act_d2  <= act_d1;
            hs_d1   <= hs_t0;
            hs_d2   <= hs_d1;
            vs_d1   <= vs_t0;
            vs_d2   <= vs_d1;
            rgb_q   <= act_d2 ? bus.data_in : '0;
            hsync_q <= hs_d2;
            vsync_q <= vs_d2;
        end
    end

    assign bus.addr_out    = addr_q;
    assign bus.vga_r       = rgb_q[2];
    assign bus.vga_g       = rgb_q[1];
    assign bus.vga_b       = rgb_q[0];
    assign bus.vga_hsync   = hsync_q;
    assign bus.vga_vsync   = vsync_q;
    // Gated by reset so the pulse lands on the first clock after release, not during reset.
    assign bus.frame_start = ~reset && (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench for vga_frame_reader: full-timing, reduced-timing and narrow-buffer instances,
// each fed by a behavioural one-cycle RAM holding ram[a] = a[2:0].
module tb_vga_frame_reader;
    localparam int K_ADDR = 0;
    localparam int K_RGB  = 1;
    localparam int K_HS   = 2;
    localparam int K_VS   = 3;
    localparam int K_FS   = 4;

    localparam int HT_A = 800;
    localparam int HT_B = 48;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   c0 = 0;
    int   a_cyc = 0;

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_frame_reader_if #(.AW(15), .DW(3)) bus_a ();
    vga_frame_reader_if #(.AW(15), .DW(3)) bus_b ();
    vga_frame_reader_if #(.AW(15), .DW(3)) bus_c ();

    vga_frame_reader dut_a (.clk(clk), .reset(reset), .bus(bus_a));

    vga_frame_reader #(
        .FB_W(8), .FB_H(4), .SCALE_SHIFT(2),
        .H_VIS(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_VIS(16), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    vga_frame_reader #(.FB_W(100)) dut_c (.clk(clk), .reset(reset), .bus(bus_c));

    always @(posedge clk) begin
        bus_a.data_in <= bus_a.addr_out[2:0];
        bus_b.data_in <= bus_b.addr_out[2:0];
        bus_c.data_in <= bus_c.addr_out[2:0];
    end

    typedef struct {
        int          c;
        int          sel;
        int          kind;
        logic [31:0] exp;
    } chk_t;

    chk_t        q[$];
    chk_t        mon_e;
    logic [31:0] mon_act;

    task automatic push(input int c, input int sel, input int kind, input logic [31:0] exp);
        chk_t e;
        int   i;
        e.c = c; e.sel = sel; e.kind = kind; e.exp = exp;
        i = q.size();
        while (i > 0 && q[i-1].c > c) i--;
        q.insert(i, e);
    endtask

    // Pixel (h,v) is at T0 in cycle c0 + v*htot + h; address appears at T1, pins at T3.
    task automatic px(input int sel, input int htot, input int kind, input int h, input int v,
                      input logic [31:0] exp);
        int lat;
        lat = (kind == K_ADDR) ? 1 : 3;
        push(c0 + v * htot + h + lat, sel, kind, exp);
    endtask

    function automatic logic [31:0] obs(input int sel, input int kind);
        logic [31:0] r;
        r = 32'hdead_beef;
        case (sel)
            0: case (kind)
                K_ADDR: r = 32'(bus_a.addr_out);
                K_RGB:  r = 32'({bus_a.vga_r, bus_a.vga_g, bus_a.vga_b});
                K_HS:   r = 32'(bus_a.vga_hsync);
                K_VS:   r = 32'(bus_a.vga_vsync);
                K_FS:   r = 32'(bus_a.frame_start);
                default: r = 32'hdead_beef;
            endcase
            1: case (kind)
                K_ADDR: r = 32'(bus_b.addr_out);
                K_RGB:  r = 32'({bus_b.vga_r, bus_b.vga_g, bus_b.vga_b});
                K_HS:   r = 32'(bus_b.vga_hsync);
                K_VS:   r = 32'(bus_b.vga_vsync);
                K_FS:   r = 32'(bus_b.frame_start);
                default: r = 32'hdead_beef;
            endcase
            default: case (kind)
                K_ADDR: r = 32'(bus_c.addr_out);
                K_RGB:  r = 32'({bus_c.vga_r, bus_c.vga_g, bus_c.vga_b});
                K_HS:   r = 32'(bus_c.vga_hsync);
                K_VS:   r = 32'(bus_c.vga_vsync);
                K_FS:   r = 32'(bus_c.frame_start);
                default: r = 32'hdead_beef;
            endcase
        endcase
        return r;
    endfunction

    function automatic string kname(input int kind);
        case (kind)
            K_ADDR:  return "addr_out";
            K_RGB:   return "rgb";
            K_HS:    return "hsync";
            K_VS:    return "vsync";
            default: return "frame_start";
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].c <= cyc) begin
            mon_e   = q.pop_front();
            mon_act = obs(mon_e.sel, mon_e.kind);
            total++;
            if (mon_e.c != cyc) begin
                bad++;
                $display("FAIL late_%s dut%0d due=%0d now=%0d", kname(mon_e.kind), mon_e.sel,
                         mon_e.c, cyc);
            end else if (mon_act !== mon_e.exp) begin
                bad++;
                $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", kname(mon_e.kind),
                         mon_e.sel, cyc - c0, mon_act, mon_e.exp);
            end
        end
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        push(cyc, 0, K_FS, 1);

        // Run into the middle of line 0 so the pipeline holds live pixels, then reset.
        repeat (300) @(posedge clk);
        #1 reset = 1'b1;
        a_cyc = cyc;
        push(a_cyc, 0, K_FS, 0);
        for (int k = 1; k <= 4; k++) begin
            push(a_cyc + k, 0, K_ADDR, 0);
            push(a_cyc + k, 0, K_RGB,  0);
            push(a_cyc + k, 0, K_HS,   1);
            push(a_cyc + k, 0, K_VS,   1);
            push(a_cyc + k, 0, K_FS,   0);
        end
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        c0 = cyc;

        // Full-timing instance: frame start, flush, addressing, data alignment, sync.
        push(c0,     0, K_FS, 1);
        push(c0 + 1, 0, K_FS, 0);
        push(c0 + 800, 0, K_FS, 0);
        push(c0,     0, K_ADDR, 0);
        for (int k = 0; k < 3; k++) push(c0 + k, 0, K_RGB, 0);
        px(0, HT_A, K_ADDR, 0,   0, 0);
        px(0, HT_A, K_ADDR, 3,   0, 0);
        px(0, HT_A, K_ADDR, 4,   0, 1);
        px(0, HT_A, K_ADDR, 7,   0, 1);
        px(0, HT_A, K_ADDR, 8,   0, 2);
        px(0, HT_A, K_ADDR, 636, 0, 159);
        px(0, HT_A, K_ADDR, 639, 0, 159);
        px(0, HT_A, K_ADDR, 640, 0, 0);
        px(0, HT_A, K_ADDR, 700, 0, 0);
        px(0, HT_A, K_ADDR, 0,   3, 0);
        px(0, HT_A, K_ADDR, 0,   4, 160);
        px(0, HT_A, K_ADDR, 5,   4, 161);
        px(0, HT_A, K_ADDR, 639, 5, 319);
        px(0, HT_A, K_RGB,  4,   0, 3'b001);
        px(0, HT_A, K_RGB,  20,  0, 3'b101);
        px(0, HT_A, K_RGB,  639, 0, 3'b111);
        px(0, HT_A, K_RGB,  640, 0, 3'b000);
        px(0, HT_A, K_RGB,  0,   4, 3'b000);
        px(0, HT_A, K_RGB,  4,   4, 3'b001);
        px(0, HT_A, K_RGB,  28,  4, 3'b111);
        px(0, HT_A, K_HS,   655, 0, 1);
        px(0, HT_A, K_HS,   656, 0, 0);
        px(0, HT_A, K_HS,   751, 0, 0);
        px(0, HT_A, K_HS,   752, 0, 1);
        px(0, HT_A, K_HS,   656, 1, 0);
        px(0, HT_A, K_VS,   0,   0, 1);
        px(0, HT_A, K_VS,   700, 2, 1);

        // Reduced-timing instance (48x23 totals, 8x4 buffer): frame wrap and vsync.
        push(c0,        1, K_FS, 1);
        push(c0 + 1103, 1, K_FS, 0);
        push(c0 + 1104, 1, K_FS, 1);
        push(c0 + 1105, 1, K_FS, 0);
        px(1, HT_B, K_ADDR, 0,  3,  0);
        px(1, HT_B, K_ADDR, 0,  4,  8);
        px(1, HT_B, K_ADDR, 31, 15, 31);
        px(1, HT_B, K_ADDR, 32, 0,  0);
        px(1, HT_B, K_ADDR, 0,  16, 0);
        px(1, HT_B, K_ADDR, 0,  23, 0);
        px(1, HT_B, K_ADDR, 4,  23, 1);
        px(1, HT_B, K_ADDR, 0,  27, 8);
        px(1, HT_B, K_RGB,  31, 15, 3'b111);
        px(1, HT_B, K_RGB,  4,  4,  3'b001);
        px(1, HT_B, K_RGB,  32, 15, 3'b000);
        px(1, HT_B, K_HS,   35, 0,  1);
        px(1, HT_B, K_HS,   36, 0,  0);
        px(1, HT_B, K_HS,   43, 0,  0);
        px(1, HT_B, K_HS,   44, 0,  1);
        px(1, HT_B, K_VS,   0,  17, 1);
        px(1, HT_B, K_VS,   0,  18, 0);
        px(1, HT_B, K_VS,   47, 19, 0);
        px(1, HT_B, K_VS,   0,  20, 1);

        // Narrow buffer (FB_W=100): right of h=400 is blank.
        px(2, HT_A, K_ADDR, 399, 0, 99);
        px(2, HT_A, K_ADDR, 400, 0, 0);
        px(2, HT_A, K_ADDR, 639, 0, 0);
        px(2, HT_A, K_ADDR, 399, 4, 199);
        px(2, HT_A, K_ADDR, 400, 4, 0);
        px(2, HT_A, K_RGB,  399, 0, 3'b011);
        px(2, HT_A, K_RGB,  400, 0, 3'b000);
        px(2, HT_A, K_RGB,  4,   4, 3'b101);
        px(2, HT_A, K_RGB,  500, 4, 3'b000);

        for (int k = 0; k < 8000 && q.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        while (q.size() > 0) begin
            mon_e = q.pop_front();
            total++;
            bad++;
            $display("FAIL timeout_%s dut%0d due=%0d now=%0d", kname(mon_e.kind), mon_e.sel,
                     mon_e.c, cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
